// File: rtl/hatch_loader_pkg.sv
// Shared widths, FSM state encoding and the byte-merge helper for the hatch loader.
// Optional feature macro used by this slice: HATCH_LOADER_CHECKSUM_EN.
package hatch_loader_pkg;

    localparam int INSTR_W = 48;
    localparam int ADDR_W  = 32;
    localparam int BYTES_PER_WORD = INSTR_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Place byte number idx of a word into its big-endian lane (byte 0 -> bits 47:40).
    function automatic logic [INSTR_W-1:0] merge_byte(input logic [INSTR_W-1:0] acc,
                                                      input logic [7:0]         b,
                                                      input logic [2:0]         idx);
        logic [INSTR_W-1:0] lane;
        logic [5:0]         sh;
        lane = {{(INSTR_W-8){1'b0}}, b};
        sh   = 6'd8 * (6'd5 - {3'b000, idx});
        return acc | (lane << sh);
    endfunction

endpackage

// File: rtl/hatch_loader_if.sv
// Host byte stream, CPU fetch port and loader status bundled for the hatch loader.
// Handshake: a byte transfers on a rising clk edge where load_valid && load_ready;
// load_byte/load_last must be stable while load_valid is high, and load_ready never waits on load_valid.
interface hatch_loader_if;
    import hatch_loader_pkg::*;

    logic [ADDR_W-1:0]  hatch_address;
    logic [INSTR_W-1:0] hatch_instruction;
    logic               load_start;
    logic               load_valid;
    logic [7:0]         load_byte;
    logic               load_last;
    logic               load_ready;
    logic               cpu_rst_b;
    logic               load_done;
    logic               load_overflow;
    logic [7:0]         load_checksum;

    modport master (
        output hatch_address, load_start, load_valid, load_byte, load_last,
        input  hatch_instruction, load_ready, cpu_rst_b, load_done, load_overflow, load_checksum
    );

    modport slave (
        input  hatch_address, load_start, load_valid, load_byte, load_last,
        output hatch_instruction, load_ready, cpu_rst_b, load_done, load_overflow, load_checksum
    );

endinterface

// File: rtl/hatch_loader_ram.sv
// Instruction memory: one write port, one synchronous read port returning old data on collision.
module hatch_loader_ram #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WIDTH      = 48
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Both updates are non-blocking, so a same-address read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/hatch_loader.sv
// Boot loader: packs host bytes into 48-bit words, holds the CPU in reset until loaded.
// Define HATCH_LOADER_CHECKSUM_EN to build the running XOR checksum of accepted bytes.
module hatch_loader
    import hatch_loader_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic          clk,
    input  logic          rst,
    hatch_loader_if.slave bus,
    output state_t        dbg_state
);

    state_t                 state_q, state_d;
    logic                   load_ready_c;
    logic                   run_d;
    logic                   accept;
    logic                   full;
    logic                   word_end;
    logic                   we;
    logic [DEPTH_LOG2:0]    ptr;
    logic [2:0]             byte_cnt;
    logic [INSTR_W-1:0]     word_buf;
    logic [INSTR_W-1:0]     wdata;
    logic                   cpu_rst_b_q;
    logic                   load_done_q;
    logic                   overflow_q;
    logic                   rd_zero_q;
    logic [INSTR_W-1:0]     ram_rdata;

    // A start pulse owns the cycle: any byte offered alongside it is dropped.
    assign accept   = bus.load_valid && load_ready_c && !bus.load_start;
    assign full     = ptr[DEPTH_LOG2];
    assign word_end = (byte_cnt == 3'd5) || bus.load_last;
    assign wdata    = merge_byte(word_buf, bus.load_byte, byte_cnt);
    assign we       = !rst && accept && !full && word_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.load_start) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: if (accept && bus.load_last) state_d = ST_RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        load_ready_c = (state_q == ST_LOAD);
        run_d        = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rst_b_q <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            cpu_rst_b_q <= run_d;
            load_done_q <= run_d;
        end
    end

    // Word assembly; the buffer is cleared after each write so the merge only ORs.
    always_ff @(posedge clk) begin
        if (rst || bus.load_start) begin
            ptr        <= '0;
            byte_cnt   <= 3'd0;
            word_buf   <= '0;
            overflow_q <= 1'b0;
        end else if (accept) begin
            if (full) begin
                overflow_q <= 1'b1;
            end else if (word_end) begin
                if (byte_cnt == 3'd5) begin
                    ptr <= ptr + {{DEPTH_LOG2{1'b0}}, 1'b1};
                end
                byte_cnt <= 3'd0;
                word_buf <= '0;
            end else begin
                byte_cnt <= byte_cnt + 3'd1;
                word_buf <= wdata;
            end
        end
    end

`ifdef HATCH_LOADER_CHECKSUM_EN
    logic [7:0] checksum_q;

    always_ff @(posedge clk) begin
        if (rst || bus.load_start) begin
            checksum_q <= 8'h00;
        end else if (accept) begin
            checksum_q <= checksum_q ^ bus.load_byte;
        end
    end

    assign bus.load_checksum = checksum_q;
`else
    assign bus.load_checksum = 8'h00;
`endif

    hatch_loader_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (INSTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (ptr[DEPTH_LOG2-1:0]),
        .wdata (wdata),
        .raddr (bus.hatch_address[DEPTH_LOG2-1:0]),
        .rdata (ram_rdata)
    );

    // Out-of-range fetches and the reset cycle force the returned word to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_zero_q <= 1'b1;
        end else begin
            rd_zero_q <= ((bus.hatch_address >> DEPTH_LOG2) != '0);
        end
    end

    assign bus.hatch_instruction = rd_zero_q ? '0 : ram_rdata;
    assign bus.load_ready        = load_ready_c;
    assign bus.cpu_rst_b         = cpu_rst_b_q;
    assign bus.load_done         = load_done_q;
    assign bus.load_overflow     = overflow_q;
    assign dbg_state             = state_q;

endmodule

// File: tb/tb_hatch_loader.sv
// Directed bench for hatch_loader: default-depth DUT plus a DEPTH_LOG2=2 DUT for overflow.
module tb_hatch_loader;
    import hatch_loader_pkg::*;

`ifdef HATCH_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic   clk;
    logic   rst;
    state_t st_a, st_b;
    int     n_cmp;
    int     n_mis;
    logic [INSTR_W-1:0] exp_q[$];
    logic [INSTR_W-1:0] rd;

    hatch_loader_if bus_a ();
    hatch_loader_if bus_b ();

    hatch_loader u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_a.slave),
        .dbg_state (st_a)
    );

    hatch_loader #(.DEPTH_LOG2(2)) u_dut_small (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_b.slave),
        .dbg_state (st_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [INSTR_W-1:0] obs, input logic [INSTR_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // drivers
    task automatic start_a();
        bus_a.load_start = 1'b1;
        tick();
        bus_a.load_start = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] b, input logic last);
        bus_a.load_valid = 1'b1;
        bus_a.load_byte  = b;
        bus_a.load_last  = last;
        tick();
        bus_a.load_valid = 1'b0;
        bus_a.load_last  = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b, input logic last);
        bus_b.load_valid = 1'b1;
        bus_b.load_byte  = b;
        bus_b.load_last  = last;
        tick();
        bus_b.load_valid = 1'b0;
        bus_b.load_last  = 1'b0;
    endtask

    task automatic read_a(input logic [ADDR_W-1:0] addr, output logic [INSTR_W-1:0] data);
        bus_a.hatch_address = addr;
        tick();
        data = bus_a.hatch_instruction;
    endtask

    task automatic read_b(input logic [ADDR_W-1:0] addr, output logic [INSTR_W-1:0] data);
        bus_b.hatch_address = addr;
        tick();
        data = bus_b.hatch_instruction;
    endtask

    // scoreboard: pop expected words in address order starting at 0
    task automatic drain_a(input string tag);
        int i;
        i = 0;
        while (exp_q.size() > 0) begin
            read_a(ADDR_W'(i), rd);
            check($sformatf("%s_w%0d", tag, i), rd, exp_q.pop_front());
            i++;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        bus_a.hatch_address = '0; bus_a.load_start = 0; bus_a.load_valid = 0;
        bus_a.load_byte = '0; bus_a.load_last = 0;
        bus_b.hatch_address = '0; bus_b.load_start = 0; bus_b.load_valid = 0;
        bus_b.load_byte = '0; bus_b.load_last = 0;

        // reset values, then idle with no load
        rst = 1'b1;
        repeat (3) tick();
        check("rst_state", 48'(st_a), 48'(ST_IDLE));
        check("rst_cpu_rst_b", 48'(bus_a.cpu_rst_b), 48'd0);
        check("rst_ready", 48'(bus_a.load_ready), 48'd0);
        check("rst_done", 48'(bus_a.load_done), 48'd0);
        check("rst_ovf", 48'(bus_a.load_overflow), 48'd0);
        check("rst_ck", 48'(bus_a.load_checksum), 48'd0);
        check("rst_instr", bus_a.hatch_instruction, 48'd0);
        rst = 1'b0;
        repeat (8) tick();
        check("idle_cpu_rst_b", 48'(bus_a.cpu_rst_b), 48'd0);
        check("idle_done", 48'(bus_a.load_done), 48'd0);
        check("idle_ready", 48'(bus_a.load_ready), 48'd0);

        // 12-byte program, two full words
        start_a();
        check("ld_state", 48'(st_a), 48'(ST_LOAD));
        check("ld_ready", 48'(bus_a.load_ready), 48'd1);
        for (int i = 1; i <= 11; i++) send_a(8'(i), 1'b0);
        check("ld_pre_cpu_rst_b", 48'(bus_a.cpu_rst_b), 48'd0);
        send_a(8'h0C, 1'b1);
        check("ld_cpu_rst_b", 48'(bus_a.cpu_rst_b), 48'd1);
        check("ld_done", 48'(bus_a.load_done), 48'd1);
        check("ld_run", 48'(st_a), 48'(ST_RUN));
        check("ld_ready_run", 48'(bus_a.load_ready), 48'd0);
        check("ld_ck", 48'(bus_a.load_checksum), CK_EN ? 48'h0C : 48'h00);
        exp_q.push_back(48'h010203040506);
        exp_q.push_back(48'h0708090A0B0C);
        drain_a("ld12");
        read_a(32'h0000_0400, rd);
        check("oob_big", rd, 48'h0);

        // short program; fetch of word 0 during its rewrite sees old data
        start_a();
        send_a(8'hAA, 1'b0);
        bus_a.hatch_address = 32'd0;
        send_a(8'hBB, 1'b1);
        check("rw_old", bus_a.hatch_instruction, 48'h010203040506);
        check("short_run", 48'(st_a), 48'(ST_RUN));
        check("short_ck", 48'(bus_a.load_checksum), CK_EN ? 48'h11 : 48'h00);
        exp_q.push_back(48'hAABB00000000);
        exp_q.push_back(48'h0708090A0B0C);
        drain_a("short");

        // restart mid-word; start with a simultaneous byte drops that byte
        start_a();
        send_a(8'h11, 1'b0);
        send_a(8'h22, 1'b0);
        send_a(8'h33, 1'b0);
        bus_a.load_start = 1'b1;
        bus_a.load_valid = 1'b1;
        bus_a.load_byte  = 8'h44;
        tick();
        bus_a.load_start = 1'b0;
        bus_a.load_valid = 1'b0;
        check("restart_ck", 48'(bus_a.load_checksum), 48'h00);
        for (int i = 1; i <= 5; i++) send_a(8'h50 + 8'(i), 1'b0);
        send_a(8'h56, 1'b1);
        check("restart_run", 48'(st_a), 48'(ST_RUN));
        check("restart_ck6", 48'(bus_a.load_checksum), CK_EN ? 48'h07 : 48'h00);
        check("restart_ovf", 48'(bus_a.load_overflow), 48'd0);
        exp_q.push_back(48'h515253545556);
        exp_q.push_back(48'h0708090A0B0C);
        drain_a("restart");

        // reset during a load abandons the partial word
        start_a();
        for (int i = 1; i <= 6; i++) send_a(8'h60 + 8'(i), 1'b0);
        send_a(8'h71, 1'b0);
        send_a(8'h72, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstld_state", 48'(st_a), 48'(ST_IDLE));
        check("rstld_cpu_rst_b", 48'(bus_a.cpu_rst_b), 48'd0);
        check("rstld_ready", 48'(bus_a.load_ready), 48'd0);
        check("rstld_ck", 48'(bus_a.load_checksum), 48'd0);
        exp_q.push_back(48'h616263646566);
        exp_q.push_back(48'h0708090A0B0C);
        drain_a("rstld");

        // small DUT: 25 bytes into a 4-word memory
        bus_b.load_start = 1'b1;
        tick();
        bus_b.load_start = 1'b0;
        for (int i = 1; i <= 24; i++) send_b(8'(i), 1'b0);
        check("ovf_pre", 48'(bus_b.load_overflow), 48'd0);
        send_b(8'd25, 1'b1);
        check("ovf_flag", 48'(bus_b.load_overflow), 48'd1);
        check("ovf_run", 48'(st_b), 48'(ST_RUN));
        check("ovf_cpu_rst_b", 48'(bus_b.cpu_rst_b), 48'd1);
        check("ovf_ck", 48'(bus_b.load_checksum), CK_EN ? 48'h01 : 48'h00);
        read_b(32'd0, rd);
        check("ovf_w0", rd, 48'h010203040506);
        read_b(32'd3, rd);
        check("ovf_w3", rd, 48'h131415161718);
        read_b(32'h0000_0010, rd);
        check("ovf_oob", rd, 48'h0);
        read_b(32'd2, rd);
        check("ovf_w2", rd, 48'h0D0E0F101112);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/hatch_loader.md
HATCH_LOADER -- requirements
Module: hatch_loader

Interface
REQ-001 Parameter: DEPTH_LOG2, default 10, log2 of instruction-memory depth in 48-bit words.
REQ-002 Port: clk  input  1  single clock; all logic rising-edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: hatch_address  input  32  fetch word address from the CPU fetch stage.
REQ-005 Port: hatch_instruction  output  48  instruction word returned to the CPU.
REQ-006 Port: load_start  input  1  one-cycle pulse that begins a program load.
REQ-007 Port: load_valid  input  1  host byte valid.
REQ-008 Port: load_byte  input  8  host program byte.
REQ-009 Port: load_last  input  1  qualifies the final byte of the program.
REQ-010 Port: load_ready  output  1  loader accepts a byte this cycle.
REQ-011 Port: cpu_rst_b  output  1  active-low reset driven to the CPU; low unless the FSM is in RUN.
REQ-012 Port: load_done  output  1  program loaded; CPU running.
REQ-013 Port: load_overflow  output  1  sticky flag: a byte arrived after memory filled.
REQ-014 Port: load_checksum  output  8  XOR of all accepted bytes in the current load.

Function
REQ-015 The FSM SHALL have three states: IDLE, LOAD, RUN.
REQ-016 Transitions: reset -> IDLE. load_start in any state -> LOAD, clearing word pointer, byte counter, checksum and overflow. LOAD with last byte accepted -> RUN. RUN holds until load_start.
REQ-017 load_start SHALL take priority over a byte handshake in the same cycle; that byte is dropped.
REQ-018 load_ready SHALL be 1 in LOAD only; a byte is accepted when load_valid and load_ready are both 1.
REQ-019 Bytes SHALL be big-endian: byte 0 of each word goes to bits 47:40, byte 5 to bits 7:0.
REQ-020 On the 6th accepted byte of a word, the full word (including that byte) SHALL be written at the word pointer in the same cycle; the pointer then increments and the byte counter returns to 0.
REQ-021 load_last on byte k<5 of a word SHALL write that partial word with the unfilled low bytes as zero.
REQ-022 With the pointer at 2^DEPTH_LOG2, further accepted bytes SHALL be discarded and SHALL set load_overflow; load_last still moves the FSM to RUN.
REQ-023 Reads: hatch_instruction SHALL equal the word at hatch_address[DEPTH_LOG2-1:0] one cycle after hatch_address is presented (registered read).
REQ-024 When any of hatch_address[31:DEPTH_LOG2] is nonzero, hatch_instruction SHALL be 48'h0 on the following cycle.
REQ-025 When a read and a write hit the same address in the same cycle, the read SHALL return the old data.
REQ-026 cpu_rst_b and load_done SHALL be registered; both rise in the cycle after load_last is accepted.

Reset
REQ-027 After rst: state IDLE, cpu_rst_b=0, load_ready=0, load_done=0, load_overflow=0, load_checksum=0, hatch_instruction=0, pointer=0, byte counter=0.
REQ-028 Memory contents SHALL NOT be cleared by rst.
REQ-029 rst during LOAD SHALL abandon the load; the partial word is not written.

Configuration
REQ-030 Macro HATCH_LOADER_CHECKSUM_EN: when defined, load_checksum = XOR of every accepted byte, including overflow-discarded bytes, and is cleared by load_start.
REQ-031 When HATCH_LOADER_CHECKSUM_EN is undefined, load_checksum SHALL be tied to 8'h00 and no checksum register exists.

Structure
REQ-032 A shared package SHALL hold: the instruction width (48), the address width (32), and the FSM state enum.
REQ-033 Memory SHALL be the sub-module hatch_loader_ram: 1 read port, 1 write port, synchronous read, read-old-data behaviour.

Verification
REQ-034 Reset, then no load -> cpu_rst_b=0, load_done=0, load_ready=0 indefinitely.
REQ-035 load_start, then 12 bytes 01..0C with load_last on 0C -> word0=48'h010203040506, word1=48'h0708090A0B0C; cpu_rst_b=1 the cycle after 0C; hatch_address=1 returns 48'h0708090A0B0C one cycle later.
REQ-036 load_start, then bytes AA,BB with last on BB -> word0=48'hAABB00000000; FSM in RUN.
REQ-037 DEPTH_LOG2=2, 25 bytes with last on byte 25 -> 4 words written, load_overflow=1, RUN reached; hatch_address=32'h10 -> 48'h0.
REQ-038 load_start mid-word after 3 bytes, then 6 new bytes -> word0 holds only the new bytes; with HATCH_LOADER_CHECKSUM_EN, checksum = XOR of the new 6 bytes only.
REQ-039 rst asserted during LOAD -> IDLE next cycle; cpu_rst_b=0; previously written words are still readable.
